// File: rtl/elapsed_up_timer_pkg.sv
// Shared types and constants for the elapsed-time up-counter.
// Digit limits, digit widths and the controller state encoding.
package elapsed_up_timer_pkg;

    localparam int UNIT_MAX = 9;
    localparam int TENS_MAX = 5;
    localparam int UNIT_W   = 4;
    localparam int TENS_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_FULL
    } state_t;

endpackage

// File: rtl/elapsed_up_timer_if.sv
// Command strobes and MM:SS readout bundle of the elapsed-time counter.
// master drives the commands, slave is the counter itself.
interface elapsed_up_timer_if;
    import elapsed_up_timer_pkg::*;

    logic              tick;
    logic              start;
    logic              stop;
    logic              clear;
    logic [UNIT_W-1:0] sec_units;
    logic [TENS_W-1:0] sec_tens;
    logic [UNIT_W-1:0] min_units;
    logic [TENS_W-1:0] min_tens;
    logic              running;
    logic              minute_pulse;
    logic              full;

    modport master (
        output tick, start, stop, clear,
        input  sec_units, sec_tens, min_units, min_tens,
        input  running, minute_pulse, full
    );

    modport slave (
        input  tick, start, stop, clear,
        output sec_units, sec_tens, min_units, min_tens,
        output running, minute_pulse, full
    );

endinterface

// File: rtl/elapsed_up_timer_bcd_up_digit.sv
// One BCD up-counting digit: wraps MAX->0 on carry_in, carry_out is
// combinational so a chain of digits ripples within one cycle.
module bcd_up_digit #(
    parameter int MAX   = 9,
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             carry_in,
    output logic [WIDTH-1:0] q,
    output logic             carry_out
);

    logic at_max;

    assign at_max    = (q == WIDTH'(MAX));
    assign carry_out = carry_in && at_max;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (carry_in) begin
            q <= at_max ? '0 : q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/elapsed_up_timer.sv
// Elapsed MM:SS up-counter. ELAPSED_WRAP_EN makes full scale wrap to
// 00:00 instead of saturating in the FULL state.
module elapsed_up_timer
    import elapsed_up_timer_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5
) (
    input logic                 clock,
    input logic                 reset,
    elapsed_up_timer_if.slave   bus
);

    state_t            state;
    logic [UNIT_W-1:0] su, mu;
    logic [TENS_W-1:0] stn, mt;
    logic              c_su, c_st, c_mu, c_mt;
    logic              cmd_run, at_full, count_en, overflow;
    logic              running_q, full_q, minute_q;

    assign at_full = (su == UNIT_W'(UNIT_MAX)) && (stn == TENS_W'(TENS_MAX))
                  && (mu == UNIT_W'(UNIT_MAX)) && (mt == TENS_W'(MIN_TENS_MAX));

    // clear and stop both swallow a coincident tick
    assign cmd_run  = (state == ST_RUN) && bus.tick && !bus.clear && !bus.stop;
    assign overflow = c_mt || (cmd_run && at_full);

`ifdef ELAPSED_WRAP_EN
    assign count_en = cmd_run;
`else
    assign count_en = cmd_run && !at_full;
`endif

    bcd_up_digit #(.MAX(UNIT_MAX), .WIDTH(UNIT_W)) u_sec_units (
        .clock(clock), .reset(reset), .clear(bus.clear),
        .carry_in(count_en), .q(su), .carry_out(c_su)
    );

    bcd_up_digit #(.MAX(TENS_MAX), .WIDTH(TENS_W)) u_sec_tens (
        .clock(clock), .reset(reset), .clear(bus.clear),
        .carry_in(c_su), .q(stn), .carry_out(c_st)
    );

    bcd_up_digit #(.MAX(UNIT_MAX), .WIDTH(UNIT_W)) u_min_units (
        .clock(clock), .reset(reset), .clear(bus.clear),
        .carry_in(c_st), .q(mu), .carry_out(c_mu)
    );

    bcd_up_digit #(.MAX(MIN_TENS_MAX), .WIDTH(TENS_W)) u_min_tens (
        .clock(clock), .reset(reset), .clear(bus.clear),
        .carry_in(c_mu), .q(mt), .carry_out(c_mt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            running_q <= 1'b0;
            full_q    <= 1'b0;
            minute_q  <= 1'b0;
        end else begin
            minute_q <= c_st;
`ifdef ELAPSED_WRAP_EN
            full_q <= 1'b0;
`endif
            if (bus.clear) begin
                state     <= ST_IDLE;
                running_q <= 1'b0;
                full_q    <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_PAUSE: begin
                        if (bus.start && !bus.stop) begin
                            state     <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (bus.stop) begin
                            state     <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (overflow) begin
`ifdef ELAPSED_WRAP_EN
                            full_q <= 1'b1;
`else
                            state     <= ST_FULL;
                            running_q <= 1'b0;
                            full_q    <= 1'b1;
`endif
                        end
                    end
                    ST_FULL: begin
                        state <= ST_FULL;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sec_units    = su;
    assign bus.sec_tens     = stn;
    assign bus.min_units    = mu;
    assign bus.min_tens     = mt;
    assign bus.running      = running_q;
    assign bus.full         = full_q;
    assign bus.minute_pulse = minute_q;

endmodule

// File: tb/tb_elapsed_up_timer.sv
// Directed bench for elapsed_up_timer: a command/expectation table
// plus hand-written multi-cycle sequences.
module tb_elapsed_up_timer;
    import elapsed_up_timer_pkg::*;

    localparam int MTM = 5;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    elapsed_up_timer_if bus();

    elapsed_up_timer #(.MIN_TENS_MAX(MTM)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct {
        logic       tick;
        logic       start;
        logic       stop;
        logic       clear;
        int         m;
        int         s;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] mmss(input int m, input int s);
        return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [13:0] digits();
        return {bus.min_tens, bus.min_units, bus.sec_tens, bus.sec_units};
    endfunction

    function automatic logic [2:0] status();
        return {bus.running, bus.full, bus.minute_pulse};
    endfunction

    task automatic step(input logic t, input logic s,
                        input logic p, input logic c);
        @(negedge clock);
        bus.tick  = t;
        bus.start = s;
        bus.stop  = p;
        bus.clear = c;
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    int mp_cnt;
    int mp_at;
    int run_hi;

    initial begin
        // {tick,start,stop,clear, MM, SS, {running,full,minute_pulse}}
        vecs[0]  = '{0, 1, 0, 0, 0, 0, 3'b100};
        vecs[1]  = '{1, 0, 0, 0, 0, 1, 3'b100};
        vecs[2]  = '{1, 0, 0, 0, 0, 2, 3'b100};
        vecs[3]  = '{1, 0, 1, 0, 0, 2, 3'b000};
        vecs[4]  = '{1, 0, 0, 0, 0, 2, 3'b000};
        vecs[5]  = '{1, 1, 0, 0, 0, 2, 3'b100};
        vecs[6]  = '{1, 0, 0, 0, 0, 3, 3'b100};
        vecs[7]  = '{0, 1, 0, 1, 0, 0, 3'b000};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 3'b000};
        vecs[9]  = '{0, 0, 1, 0, 0, 0, 3'b000};
        vecs[10] = '{1, 1, 0, 0, 0, 0, 3'b100};
        vecs[11] = '{1, 0, 0, 0, 0, 1, 3'b100};

        bus.tick  = 0;
        bus.start = 0;
        bus.stop  = 0;
        bus.clear = 0;
        reset     = 0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_digits", 32'(digits()), 32'(mmss(0, 0)));
        check("reset_status", 32'(status()), 32'(3'b000));
        @(negedge clock);
        reset = 1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].tick, vecs[i].start, vecs[i].stop, vecs[i].clear);
            check($sformatf("vec%0d", i), 32'({digits(), status()}),
                  32'({mmss(vecs[i].m, vecs[i].s), vecs[i].st}));
        end

        // 75 seconds, one minute rollover
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        mp_cnt = 0;
        mp_at  = 0;
        for (int i = 1; i <= 75; i++) begin
            step(1, 0, 0, 0);
            if (bus.minute_pulse) begin
                mp_cnt++;
                mp_at = i;
            end
        end
        check("t75_digits", 32'(digits()), 32'(mmss(1, 15)));
        check("t75_mp_count", mp_cnt, 1);
        check("t75_mp_tick", mp_at, 60);

        // pause and resume
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        ticks(10);
        step(0, 0, 1, 0);
        run_hi = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            if (bus.running) run_hi++;
        end
        check("pause_running", run_hi, 0);
        check("pause_digits", 32'(digits()), 32'(mmss(0, 10)));
        step(0, 1, 0, 0);
        ticks(3);
        check("resume_digits", 32'(digits()), 32'(mmss(0, 13)));
        check("resume_running", 32'(bus.running), 32'(1));

        // start+tick and stop+tick coincidences
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        check("start_tick", 32'({digits(), status()}),
              32'({mmss(0, 0), 3'b100}));
        ticks(5);
        check("five_ticks", 32'(digits()), 32'(mmss(0, 5)));
        step(1, 0, 1, 0);
        check("stop_tick", 32'({digits(), status()}),
              32'({mmss(0, 5), 3'b000}));

        // full scale
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        ticks(MTM * 600 + 599);
        check("at_full", 32'({digits(), status()}),
              32'({mmss(MTM * 10 + 9, 59), 3'b100}));
        step(1, 0, 0, 0);
`ifdef ELAPSED_WRAP_EN
        check("wrap", 32'({digits(), status()}),
              32'({mmss(0, 0), 3'b111}));
        step(0, 0, 0, 0);
        check("wrap_after", 32'({digits(), status()}),
              32'({mmss(0, 0), 3'b100}));
`else
        check("saturate", 32'({digits(), status()}),
              32'({mmss(MTM * 10 + 9, 59), 3'b010}));
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check("full_hold", 32'({digits(), status()}),
              32'({mmss(MTM * 10 + 9, 59), 3'b010}));
        step(0, 0, 0, 1);
        check("full_clear", 32'({digits(), status()}),
              32'({mmss(0, 0), 3'b000}));
`endif

        // clear while running at 12:34
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        ticks(754);
        check("at_1234", 32'(digits()), 32'(mmss(12, 34)));
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        check("clear_idle", 32'({digits(), status()}),
              32'({mmss(0, 0), 3'b000}));

        // asynchronous reset between edges at 03:21
        step(0, 1, 0, 0);
        ticks(201);
        check("at_0321", 32'(digits()), 32'(mmss(3, 21)));
        #2;
        bus.tick = 0;
        reset    = 0;
        #1;
        check("async_reset", 32'({digits(), status()}),
              32'({mmss(0, 0), 3'b000}));
        @(negedge clock);
        reset = 1;
        step(1, 0, 0, 0);
        check("post_reset_idle", 32'({digits(), status()}),
              32'({mmss(0, 0), 3'b000}));
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check("post_reset_run", 32'({digits(), status()}),
              32'({mmss(0, 1), 3'b100}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elapsed_up_timer.md
# elapsed_up_timer

Elapsed-time up-counter for the irrigation timer: counts MM:SS upward in BCD digits from 00:00 while a valve is open, driven by the 1 Hz tick strobe. It is the counting-up counterpart of the countdown chain, recording how long watering actually ran. Digit stages cascade by carry exactly as the countdown stages cascade by borrow.

## Interface
- MIN_TENS_MAX, 5, top value of the minutes-tens digit; legal 1..7, so full scale is (MIN_TENS_MAX)9:59.

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- tick  in  1  one-cycle 1 Hz strobe; each high cycle counts as one second
- start  in  1  pulse: begin or resume counting
- stop  in  1  pulse: pause counting, hold value
- clear  in  1  pulse: zero all digits, return to IDLE
- sec_units  out  4  seconds units digit, 0..9
- sec_tens  out  3  seconds tens digit, 0..5
- min_units  out  4  minutes units digit, 0..9
- min_tens  out  3  minutes tens digit, 0..MIN_TENS_MAX
- running  out  1  high in RUN
- minute_pulse  out  1  one-cycle pulse when seconds roll 59->00
- full  out  1  high when the count sits at full scale

## Operation
- States: IDLE (count 00:00, not counting), RUN, PAUSE (value held), FULL (at full scale).
- IDLE --start--> RUN; RUN --stop--> PAUSE; PAUSE --start--> RUN; any --clear--> IDLE (digits zeroed).
- RUN with tick: sec_units+1; at 9 it wraps to 0 and carries to sec_tens; sec_tens at 5 wraps to 0 and carries to min_units; min_units at 9 wraps to 0 and carries to min_tens.
- Same-cycle input priority: clear > stop > start > tick.
- start in the same cycle as tick: state moves to RUN; that tick is not counted.
- stop in the same cycle as tick: tick is not counted.
- start in RUN, stop in PAUSE or IDLE, start in FULL: ignored.
- minute_pulse fires on each sec 59->00 rollover, including the one that reaches a new minute at full scale.
- Digits never hold non-BCD codes. Reaching digit max without a carry-in never changes higher digits.

## Timing
- All outputs are registered.
- Reset values: all digits 0, running 0, minute_pulse 0, full 0, state IDLE.
- Latency: digits update on the clock edge that samples tick high in RUN. running and full change on the edge that samples the causing command.
- minute_pulse is high for exactly the cycle after the rollover edge.
- Reset asserted mid-count: immediate zeroing, independent of clock. After release, the block waits in IDLE for start.

## Configuration
- ELAPSED_WRAP_EN defined: a tick at full scale wraps all digits to 00:00 and state stays RUN; full pulses high for one cycle at the wrap.
- ELAPSED_WRAP_EN undefined: the count saturates. The tick that would pass full scale is discarded, and state goes RUN->FULL with full held high. Only clear leaves FULL; stop in FULL is ignored.

## Structure
- Shared package: state encoding (IDLE/RUN/PAUSE/FULL), digit max constants (9, 5), digit widths.
- One sub-module: bcd_up_digit (parameters MAX and WIDTH).
  - Inputs: clock, reset, clear, carry_in.
  - Outputs: q, carry_out.
  - carry_out is combinational: carry_in AND q==MAX.
- Four instances are chained by carry. The top-level FSM gates the first carry_in with tick&&RUN.

## Test plan
- Reset, then start, then 75 ticks -> 01:15; minute_pulse seen exactly once, on tick 60.
- Start, 10 ticks, stop, 5 ticks, start, 3 ticks -> 00:13; running low during the paused ticks.
- Start and tick asserted in the same cycle, then 1 tick -> 00:01. Stop and tick in the same cycle at 00:05 -> stays 00:05.
- Count to 59:59 (MIN_TENS_MAX=5), then 1 more tick:
  - Without ELAPSED_WRAP_EN -> holds 59:59, full=1, running=0.
  - With ELAPSED_WRAP_EN -> 00:00, one-cycle full pulse, running=1.
- clear at 12:34 in RUN -> 00:00, IDLE. clear with start in the same cycle -> IDLE.
- reset pulsed low between clock edges at 03:21 -> digits read 0 before the next edge.
